corona_slot_scheduler: RTL

- Allocates and tracks the NUM_SLOTS corona object slots that feed the per-slot drawing-request/RGB lanes of the object priority mux.
- Accepts spawn requests from the game's random generator and picks a free slot round-robin.
- Enforces a minimum frame gap between spawns and frees slots on hit/exit events.
- Freezes all allocation on game timeout. Sits between the game-logic/random blocks and the corona object instances.

---
 rtl/game_pkg.sv | 16 +
 rtl/rr_free_finder.sv | 34 +++
 rtl/corona_slot_scheduler.sv | 135 +++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared types for the corona game blocks.
// Slot count, scheduler states and slot vector type.
package game_pkg;

  localparam int NUM_CORONA = 10;
  localparam int SLOT_IDX_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FROZEN = 2'd2
  } sched_state_t;

  typedef logic [NUM_CORONA-1:0] slot_vec_t;

endpackage

// File: rtl/rr_free_finder.sv
// Round-robin free slot search.
// Finds the first clear busy bit starting at rr_ptr, wrapping.
module rr_free_finder
  import game_pkg::*;
#(
  parameter int N  = NUM_CORONA,
  parameter int IW = SLOT_IDX_W
) (
  input  logic [N-1:0]  busy,
  input  logic [IW-1:0] rr_ptr,
  output logic          found,
  output logic [IW-1:0] index
);

  logic [IW:0] cand;

  // walk offsets high to low so the smallest offset wins
  always_comb begin
    found = 1'b0;
    index = '0;
    cand  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) begin
        cand = cand - (IW+1)'(N);
      end
      if (!busy[cand[IW-1:0]]) begin
        found = 1'b1;
        index = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/corona_slot_scheduler.sv
// Corona slot allocator: round-robin spawn, frame gap,
// free on hit/exit, freeze on timeout.
module corona_slot_scheduler
  import game_pkg::*;
#(
  parameter int NUM_SLOTS        = NUM_CORONA,
  parameter int SPAWN_GAP_FRAMES = 30,
  parameter int X_BITS           = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 startOfFrame,
  input  logic                 gameStart,
  input  logic                 timeout,
  input  logic                 spawnReq,
  input  logic [X_BITS-1:0]    spawnX,
  input  logic [NUM_SLOTS-1:0] slotFree,
  output logic [NUM_SLOTS-1:0] slotActive,
  output logic [NUM_SLOTS-1:0] slotLoad,
  output logic [X_BITS-1:0]    slotLoadX,
  output logic                 spawnAck,
  output logic                 spawnBlocked,
  output logic [3:0]           activeCount,
  output logic [1:0]           state
);

  localparam int IW = $clog2(NUM_SLOTS);

  sched_state_t         state_q, state_d;
  logic [NUM_SLOTS-1:0] slot_active_q, slot_active_d;
  logic [NUM_SLOTS-1:0] slot_load_q, slot_load_d;
  logic [X_BITS-1:0]    load_x_q, load_x_d;
  logic                 ack_q, ack_d;
  logic                 blocked_q, blocked_d;
  logic [3:0]           count_q, count_d;
  logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [7:0]           cooldown_q, cooldown_d;

  logic                 found;
  logic [IW-1:0]        pick;
  logic                 accept;

  rr_free_finder #(
    .N  (NUM_SLOTS),
    .IW (IW)
  ) u_finder (
    .busy   (slot_active_q),
    .rr_ptr (rr_ptr_q),
    .found  (found),
    .index  (pick)
  );

  // spawn accepted only in RUN with no restart/timeout this cycle;
  // search uses pre-free occupancy
  assign accept = (state_q == RUN) && !timeout && !gameStart &&
                  spawnReq && (cooldown_q == 8'd0) && found;

  // next-state for FSM, slots, cooldown and registered outputs
  always_comb begin
    state_d       = state_q;
    slot_active_d = slot_active_q;
    slot_load_d   = '0;
    load_x_d      = load_x_q;
    ack_d         = 1'b0;
    rr_ptr_d      = rr_ptr_q;
    cooldown_d    = cooldown_q;
    blocked_d     = (state_q == RUN) && spawnReq && (&slot_active_q);
    count_d       = '0;

    if (gameStart) begin
      state_d       = timeout ? FROZEN : RUN;
      slot_active_d = '0;
      rr_ptr_d      = '0;
      cooldown_d    = '0;
    end else if (state_q == RUN) begin
      if (timeout) begin
        state_d = FROZEN;
      end else begin
        slot_active_d = slot_active_q & ~slotFree;
        if (accept) begin
          slot_active_d[pick] = 1'b1;
          slot_load_d[pick]   = 1'b1;
          load_x_d            = spawnX;
          ack_d               = 1'b1;
          cooldown_d          = 8'(SPAWN_GAP_FRAMES);
          if (pick == IW'(NUM_SLOTS - 1)) begin
            rr_ptr_d = '0;
          end else begin
            rr_ptr_d = pick + IW'(1);
          end
        end else if (startOfFrame && cooldown_q != 8'd0) begin
          cooldown_d = cooldown_q - 8'd1;
        end
      end
    end

    for (int i = 0; i < NUM_SLOTS; i++) begin
      count_d = count_d + 4'(slot_active_d[i]);
    end
  end

  // single state register for FSM and all outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      slot_active_q <= '0;
      slot_load_q   <= '0;
      load_x_q      <= '0;
      ack_q         <= 1'b0;
      blocked_q     <= 1'b0;
      count_q       <= '0;
      rr_ptr_q      <= '0;
      cooldown_q    <= '0;
    end else begin
      state_q       <= state_d;
      slot_active_q <= slot_active_d;
      slot_load_q   <= slot_load_d;
      load_x_q      <= load_x_d;
      ack_q         <= ack_d;
      blocked_q     <= blocked_d;
      count_q       <= count_d;
      rr_ptr_q      <= rr_ptr_d;
      cooldown_q    <= cooldown_d;
    end
  end

  assign slotActive   = slot_active_q;
  assign slotLoad     = slot_load_q;
  assign slotLoadX    = load_x_q;
  assign spawnAck     = ack_q;
  assign spawnBlocked = blocked_q;
  assign activeCount  = count_q;
  assign state        = state_q;

endmodule
